// File: rtl/mem_bus_bridge.sv
// rtl/mem_bus_bridge.sv - CPU load/store to word-addressed SRAM bridge
// One CPU access becomes one req/ack SRAM transaction with lane steering and extension.
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [7:0]  cnt_q;

  logic        accept, ack_ok, tout, illegal, in_req;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c, load_c;
  logic [15:0] half_c;
  logic [7:0]  byte_c;

  assign illegal = (cpu_size == 2'b11) ||
                   (cpu_size == 2'b00 && cpu_addr[1:0] != 2'b00) ||
                   (cpu_size == 2'b01 && cpu_addr[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    ack_ok    = 1'b0;
    tout      = 1'b0;
    busy      = 1'b0;
    mem_req   = 1'b0;
    cpu_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          accept  = 1'b1;
          state_d = illegal ? DONE : REQ;
        end
      end
      REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        // Ack takes priority over the timeout limit in the same cycle.
        if (mem_ack) begin
          ack_ok  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == LIMIT) begin
          tout    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= cpu_we;
        uns_q   <= cpu_unsigned;
        size_q  <= cpu_size;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        err_q   <= illegal;
        cnt_q   <= 8'd0;
      end
      if (state_q == REQ) begin
        cnt_q <= cnt_q + 8'd1;
        if (tout) err_q <= 1'b1;
        if (ack_ok && !we_q) rdata_q <= load_c;
      end
    end
  end

  always_comb begin
    strb_c  = 4'b0000;
    wdata_c = wdata_q;
    case (size_q)
      2'b00: begin
        strb_c  = 4'b1111;
        wdata_c = wdata_q;
      end
      2'b01: begin
        strb_c  = 4'b0011 << addr_q[1:0];
        wdata_c = {2{wdata_q[15:0]}};
      end
      default: begin
        strb_c  = 4'b0001 << addr_q[1:0];
        wdata_c = {4{wdata_q[7:0]}};
      end
    endcase
    if (!we_q) strb_c = 4'b0000;
  end

  always_comb begin
    half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (addr_q[1:0])
      2'b00:   byte_c = mem_rdata[7:0];
      2'b01:   byte_c = mem_rdata[15:8];
      2'b10:   byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    case (size_q)
      2'b00:   load_c = mem_rdata;
      2'b01:   load_c = {{16{~uns_q & half_c[15]}}, half_c};
      default: load_c = {{24{~uns_q & byte_c[7]}}, byte_c};
    endcase
  end

  // SRAM-side fields are only driven while the request is live.
  assign in_req    = (state_q == REQ);
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? addr_q[31:2] : 30'd0;
  assign mem_wstrb = in_req ? strb_c : 4'b0000;
  assign mem_wdata = in_req ? wdata_c : 32'd0;
  assign cpu_err   = (state_q == DONE) & err_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb/tb_mem_bus_bridge.sv - self-checking bench for mem_bus_bridge
module tb_mem_bus_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_unsigned = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_err, busy, mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  mem_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] prev_rd = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int nb(input logic [1:0] s);
    case (s)
      2'b00:   return 4;
      2'b01:   return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit legal(input logic [1:0] s, input logic [31:0] a);
    return (s != 2'b11) && ((a % nb(s)) == 0);
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] r = 4'b0000;
    int o = int'(a % 4);
    for (int i = 0; i < 4; i++)
      if (i >= o && i < o + nb(s)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nb(s)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input bit u,
                                         input logic [31:0] a, input logic [31:0] r);
    longint v, mask;
    int n = nb(s);
    v = longint'({32'd0, r}) >> (8 * int'(a % 4));
    mask = (64'sd1 <<< (8 * n)) - 1;
    v = v & mask;
    if (!u && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // One complete access; ack is given in the (dly+1)-th request cycle.
  task automatic run(input string tag, input bit we, input logic [1:0] s, input bit u,
                     input logic [31:0] a, input logic [31:0] w, input logic [31:0] r,
                     input int dly, input logic [3:0] e_strb, input logic [31:0] e_wd,
                     input logic [31:0] e_rd, input bit e_err, input int e_reqc);
    int reqc = 0;
    bit got = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_size = s; cpu_unsigned = u;
    cpu_addr = a; cpu_wdata = w;
    tick;
    cpu_req = 1'b0;
    for (int cyc = 0; cyc < 300 && !got; cyc++) begin
      if (mem_req) begin
        reqc++;
        chk({tag, " mem_addr"}, {2'b00, mem_addr}, a >> 2);
        chk({tag, " mem_we"}, mem_we, we);
        chk({tag, " mem_wstrb"}, mem_wstrb, e_strb);
        if (we) chk({tag, " mem_wdata"}, mem_wdata, e_wd);
        mem_rdata = r;
        mem_ack = (reqc == dly + 1);
      end else begin
        mem_ack = 1'b0;
      end
      if (cpu_ready) begin
        got = 1'b1;
        chk({tag, " cpu_err"}, cpu_err, e_err);
        chk({tag, " busy_at_ready"}, busy, 1'b1);
      end else begin
        tick;
      end
    end
    if (!got) chk({tag, " ready_timeout"}, 0, 1);
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    tick;
    chk({tag, " req_cycles"}, reqc, e_reqc);
    chk({tag, " cpu_rdata"}, cpu_rdata, e_rd);
    chk({tag, " busy_after"}, busy, 1'b0);
    chk({tag, " ready_once"}, cpu_ready, 1'b0);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  s;
    bit          u;
    logic [31:0] a, w, r;
    int          dly;
    logic [3:0]  strb;
    logic [31:0] wd, rd;
    bit          err;
    int          reqc;
  } vec_t;

  vec_t tv[8];

  initial begin
    tv[0] = '{1, 2'b10, 0, 32'h103, 32'h000000AB, 32'h0, 1, 4'b1000, 32'hABABABAB, 32'h0, 0, 2};
    tv[1] = '{0, 2'b01, 0, 32'h202, 32'h0, 32'h80011234, 0, 4'b0000, 32'h0, 32'hFFFF8001, 0, 1};
    tv[2] = '{0, 2'b01, 1, 32'h202, 32'h0, 32'h80011234, 0, 4'b0000, 32'h0, 32'h00008001, 0, 1};
    tv[3] = '{0, 2'b00, 0, 32'h006, 32'h0, 32'h11111111, 0, 4'b0000, 32'h0, 32'h00008001, 1, 0};
    tv[4] = '{1, 2'b00, 0, 32'h040, 32'h12345678, 32'h0, 9, 4'b1111, 32'h12345678, 32'h00008001, 1, 4};
    tv[5] = '{0, 2'b00, 0, 32'h044, 32'h0, 32'hCAFEBABE, 3, 4'b0000, 32'h0, 32'hCAFEBABE, 0, 4};
    tv[6] = '{0, 2'b10, 0, 32'h045, 32'h0, 32'h00008000, 2, 4'b0000, 32'h0, 32'hFFFFFF80, 0, 3};
    tv[7] = '{1, 2'b11, 0, 32'h008, 32'h55, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFFFF80, 1, 0};

    #2;
    chk("reset mem_req", mem_req, 0);
    chk("reset busy", busy, 0);
    chk("reset cpu_ready", cpu_ready, 0);
    chk("reset cpu_rdata", cpu_rdata, 0);
    chk("reset mem_wstrb", mem_wstrb, 0);
    @(negedge clk);
    rst = 1'b1;
    tick;

    for (int i = 0; i < 8; i++)
      run($sformatf("vec%0d", i), tv[i].we, tv[i].s, tv[i].u, tv[i].a, tv[i].w, tv[i].r,
          tv[i].dly, tv[i].strb, tv[i].wd, tv[i].rd, tv[i].err, tv[i].reqc);
    prev_rd = 32'hFFFFFF80;

    // Back-to-back with cpu_req held; stray ack in each IDLE gap.
    begin
      int samp = 0, readies = 0, rc = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b00; cpu_unsigned = 1'b0;
      cpu_addr = 32'h10; mem_rdata = 32'h11112222;
      for (int cyc = 0; cyc < 40 && readies < 3; cyc++) begin
        tick;
        samp++;
        if (mem_req) begin
          rc++;
          mem_ack = (rc == 4);
        end else if (!busy && readies > 0) begin
          mem_ack = 1'b1;
          chk("b2b idle_req", mem_req, 0);
        end else begin
          mem_ack = 1'b0;
        end
        if (cpu_ready) begin
          readies++;
          chk("b2b req_cycles", rc, 4);
          chk("b2b err", cpu_err, 0);
          rc = 0;
          if (readies == 3) cpu_req = 1'b0;
        end
      end
      mem_ack = 1'b0;
      chk("b2b readies", readies, 3);
      chk("b2b samples", samp, 17);
      tick;
      chk("b2b no_fourth", busy, 0);
      tick;
      chk("b2b no_fourth_req", mem_req, 0);
      chk("b2b rdata", cpu_rdata, 32'h11112222);
      prev_rd = 32'h11112222;
    end

    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("stray ready", cpu_ready, 0);
    chk("stray req", mem_req, 0);

    for (int i = 0; i < 40; i++) begin
      bit we = 1'($urandom);
      logic [1:0] s = 2'($urandom_range(0, 3));
      bit u = 1'($urandom);
      logic [31:0] a = $urandom;
      logic [31:0] w = $urandom;
      logic [31:0] r = $urandom;
      int dly = $urandom_range(0, 5);
      bit lg = legal(s, a);
      bit acked = lg && (dly < TO);
      int reqc = !lg ? 0 : (acked ? dly + 1 : TO);
      if (lg && acked && !we) prev_rd = m_load(s, u, a, r);
      run($sformatf("rnd%0d", i), we, s, u, a, w, r, dly,
          we ? m_strb(s, a) : 4'b0000, m_wdata(s, w), prev_rd, !acked, reqc);
    end

    // Reset asserted during the second request cycle.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_addr = 32'h80; cpu_wdata = 32'h99;
    tick;
    cpu_req = 1'b0;
    tick;
    chk("rst pre mem_req", mem_req, 1);
    rst = 1'b0;
    #1;
    chk("rst mem_req", mem_req, 0);
    chk("rst busy", busy, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    chk("rst mem_addr", {2'b00, mem_addr}, 0);
    chk("rst cpu_rdata", cpu_rdata, 0);
    chk("rst cpu_ready", cpu_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    chk("rst idle", mem_req, 0);
    run("post_rst", 0, 2'b01, 1, 32'h302, 32'h0, 32'hBEEF0000, 1,
        4'b0000, 32'h0, 32'h0000BEEF, 0, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
